// File: rtl/seven_seg_capture.sv
// Recovers hex nibbles from a time-multiplexed, active-low 7-segment anode/cathode bus.
// Flags non-hex glyphs, tracks blank digits, and pulses once per fully scanned frame.
module seven_seg_capture #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    pattern_error,
    output logic [$clog2(NUM_DIGITS)-1:0] err_digit
);

    localparam int KW = $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

    logic [NUM_DIGITS-1:0] an_m, an_s;
    logic [6:0]            seg_m, seg_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            an_m  <= '1;
            an_s  <= '1;
            seg_m <= '1;
            seg_s <= '1;
        end else begin
            an_m  <= an;
            an_s  <= an_m;
            seg_m <= seg;
            seg_s <= seg_m;
        end
    end

    logic          samp_valid;
    logic [KW-1:0] samp_k;

    always_comb begin
        samp_k     = '0;
        samp_valid = $onehot(~an_s);
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s[i]) samp_k = KW'(i);
        end
    end

    state_t        state;
    logic [7:0]    count;
    logic [KW-1:0] lk;
    logic [6:0]    lp;
    logic          cap;

    // cap is a registered strobe; the capture itself lands one edge later,
    // using the still-latched (lk, lp).
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            lk    <= '0;
            lp    <= '0;
            cap   <= 1'b0;
        end else begin
            cap <= 1'b0;
            if (!samp_valid) begin
                state <= IDLE;
                count <= '0;
            end else if (state == IDLE || samp_k != lk || seg_s != lp) begin
                lk    <= samp_k;
                lp    <= seg_s;
                count <= 8'd1;
                if (STABLE_CYCLES == 1) begin
                    cap   <= 1'b1;
                    state <= HELD;
                end else begin
                    state <= COUNT;
                end
            end else if (state == COUNT) begin
                count <= count + 8'd1;
                if ({1'b0, count} + 9'd1 == 9'(STABLE_CYCLES)) begin
                    cap   <= 1'b1;
                    state <= HELD;
                end
            end
        end
    end

    logic       dec_ok;
    logic       dec_blank;
    logic [3:0] dec_nib;

    always_comb begin
        dec_ok    = 1'b1;
        dec_blank = 1'b0;
        dec_nib   = 4'h0;
        case (lp)
            7'b0000001: dec_nib = 4'h0;
            7'b1001111: dec_nib = 4'h1;
            7'b0010010: dec_nib = 4'h2;
            7'b0000110: dec_nib = 4'h3;
            7'b1001100: dec_nib = 4'h4;
            7'b0100100: dec_nib = 4'h5;
            7'b0100000: dec_nib = 4'h6;
            7'b0001111: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0000100: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b1100000: dec_nib = 4'hB;
            7'b0110001: dec_nib = 4'hC;
            7'b1000010: dec_nib = 4'hD;
            7'b0110000: dec_nib = 4'hE;
            7'b0111000: dec_nib = 4'hF;
            7'b1111111: begin
                dec_ok    = 1'b0;
                dec_blank = 1'b1;
            end
            default:    dec_ok = 1'b0;
        endcase
    end

    logic [NUM_DIGITS-1:0] seen, seen_nxt;

    always_comb begin
        seen_nxt     = seen;
        seen_nxt[lk] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digits_out    <= '0;
            digit_valid   <= '0;
            frame_done    <= 1'b0;
            pattern_error <= 1'b0;
            err_digit     <= '0;
            seen          <= '0;
        end else begin
            frame_done    <= 1'b0;
            pattern_error <= 1'b0;
            if (cap) begin
                digit_valid[lk] <= dec_ok;
                if (dec_ok) begin
                    digits_out[lk*4 +: 4] <= dec_nib;
                end else if (!dec_blank) begin
                    pattern_error <= 1'b1;
                    err_digit     <= lk;
                end
                if (&seen_nxt) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen <= seen_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: static digit, frame scans, glitch,
// bad/blank glyphs, invalid anodes and mid-dwell reset.
module tb_seven_seg_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic [31:0] digits_out;
    logic [7:0]  digit_valid;
    logic        frame_done;
    logic        pattern_error;
    logic [2:0]  err_digit;

    seven_seg_capture #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .an(an),
        .seg(seg),
        .digits_out(digits_out),
        .digit_valid(digit_valid),
        .frame_done(frame_done),
        .pattern_error(pattern_error),
        .err_digit(err_digit)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [31:0] fd_hist, pe_hist;
    logic        saw8;
    logic [6:0]  glyph [0:7];
    logic [31:0] keep_d;
    logic [7:0]  keep_v;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Drive pins at a falling edge, then record pulses after each of n rising edges.
    task automatic dwell(input logic [7:0] a, input logic [6:0] s, input int n);
        @(negedge clk);
        an = a;
        seg = s;
        fd_hist = '0;
        pe_hist = '0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            fd_hist[c] = frame_done;
            pe_hist[c] = pattern_error;
            if (digits_out[3:0] == 4'h8) saw8 = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        an = 8'hFF;
        seg = 7'h7F;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic scan(input logic [31:0] exp_fd7);
        for (int d = 0; d < 8; d++) begin
            dwell(~(8'd1 << d), glyph[d], 10);
            check($sformatf("scan_fd_d%0d", d), fd_hist, (d == 7) ? exp_fd7 : 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        glyph[0] = 7'b0000001; glyph[1] = 7'b1001111;
        glyph[2] = 7'b0010010; glyph[3] = 7'b0000110;
        glyph[4] = 7'b1001100; glyph[5] = 7'b0100100;
        glyph[6] = 7'b0100000; glyph[7] = 7'b0001111;
        saw8 = 1'b0;
        reset = 1'b1;
        an = 8'hFF;
        seg = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits", digits_out, 32'h0);
        check("rst_valid", {24'h0, digit_valid}, 32'h0);
        check("rst_fd", {31'h0, frame_done}, 32'h0);
        check("rst_pe", {31'h0, pattern_error}, 32'h0);
        check("rst_err", {29'h0, err_digit}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Static single digit: nothing at edge 5, capture at edge 6, stays put.
        dwell(8'hFE, 7'b0010010, 6);
        check("static_e5_valid", {24'h0, digit_valid}, 32'h0);
        dwell(8'hFE, 7'b0010010, 1);
        check("static_e6_valid", {24'h0, digit_valid}, 32'h01);
        check("static_e6_digit", digits_out, 32'h2);
        dwell(8'hFE, 7'b0010010, 13);
        check("static_hold_valid", {24'h0, digit_valid}, 32'h01);
        check("static_hold_pe", pe_hist | fd_hist, 32'h0);

        // Two full scans, each completing a frame at edge 6 of digit 7.
        do_reset();
        scan(32'h40);
        check("scan1_digits", digits_out, 32'h76543210);
        check("scan1_valid", {24'h0, digit_valid}, 32'hFF);
        scan(32'h40);
        check("scan2_digits", digits_out, 32'h76543210);

        // Glitch of "8" for 3 cycles must not be captured.
        saw8 = 1'b0;
        dwell(8'hFE, 7'b0000000, 3);
        dwell(8'hFE, 7'b1001111, 10);
        check("glitch_digit0", {28'h0, digits_out[3:0]}, 32'h1);
        check("glitch_no8", {31'h0, saw8}, 32'h0);

        // Bad pattern on digit 5, then blank.
        dwell(8'hDF, 7'b1111110, 10);
        check("bad_pe_hist", pe_hist, 32'h40);
        check("bad_err_digit", {29'h0, err_digit}, 32'h5);
        check("bad_valid", {24'h0, digit_valid}, 32'hDF);
        check("bad_keep_nib", {28'h0, digits_out[23:20]}, 32'h5);
        dwell(8'hDF, 7'b1111111, 10);
        check("blank_pe_hist", pe_hist, 32'h0);
        check("blank_valid", {24'h0, digit_valid}, 32'hDF);
        check("blank_err_digit", {29'h0, err_digit}, 32'h5);

        // Invalid anode patterns: nothing changes.
        keep_d = digits_out;
        keep_v = digit_valid;
        dwell(8'hFC, 7'b0000001, 20);
        check("multi_an_pulses", fd_hist | pe_hist, 32'h0);
        dwell(8'hFF, 7'b0000001, 20);
        check("no_an_pulses", fd_hist | pe_hist, 32'h0);
        check("invalid_digits", digits_out, keep_d);
        check("invalid_valid", {24'h0, digit_valid}, {24'h0, keep_v});
        check("invalid_count", {24'h0, dut.count}, 32'h0);

        // Reset while digit 2 has count=3.
        dwell(8'hFB, 7'b0010010, 5);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_digits", digits_out, 32'h0);
        check("midrst_valid", {24'h0, digit_valid}, 32'h0);
        check("midrst_err", {29'h0, err_digit}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("postrst_e5_valid", {24'h0, digit_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("postrst_e6_valid", {24'h0, digit_valid}, 32'h04);
        check("postrst_e6_digits", digits_out, 32'h200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
